// File: rtl/clk_div_ctrl.sv
// Run-time programmable clock divider: produces div_clk_o and a matching tick_o pulse.
// Divisor changes and stop requests take effect only at period boundaries, so no runt pulses occur.
module clk_div_ctrl #(
  parameter int CNT_W    = 8,
  parameter int DEF_HALF = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             cfg_valid_i,
  input  logic [CNT_W-1:0] cfg_half_i,
  output logic             cfg_ready_o,
  output logic             cfg_err_o,
  output logic             div_clk_o,
  output logic             tick_o,
  output logic             running_o,
  output logic [CNT_W-1:0] cur_half_o
);

  localparam logic [1:0] ST_STOPPED = 2'd0;
  localparam logic [1:0] ST_RUN     = 2'd1;
  localparam logic [1:0] ST_DRAIN   = 2'd2;

  localparam logic [CNT_W-1:0] ONE      = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] DEF_INIT = CNT_W'(DEF_HALF);

  logic [1:0]       state_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] half_q;
  logic [CNT_W-1:0] pend_q;
  logic             pend_vld;
  logic             div_clk_q;
  logic             tick_q;
  logic             cfg_err_q;

  logic             accept;
  logic             cfg_nz;
  logic             boundary;
  logic             fall;
  logic             stop_now;
  logic [CNT_W-1:0] stop_half;

  // A pending change and a fresh accept are mutually exclusive, since accept needs ready.
  always_comb begin
    accept    = cfg_valid_i & ~pend_vld;
    cfg_nz    = accept & (|cfg_half_i);
    boundary  = (count_q == (half_q - ONE));
    fall      = boundary & div_clk_q;
    stop_now  = ((state_q == ST_RUN) & ~en_i & ~div_clk_q) |
                (((state_q == ST_RUN) & ~en_i) | (state_q == ST_DRAIN)) & fall;
    stop_half = half_q;
    if (cfg_nz)
      stop_half = cfg_half_i;
    else if (pend_vld)
      stop_half = pend_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_STOPPED;
      count_q   <= '0;
      half_q    <= DEF_INIT;
      pend_q    <= '0;
      pend_vld  <= 1'b0;
      div_clk_q <= 1'b0;
      tick_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      tick_q    <= 1'b0;
      cfg_err_q <= accept & ~(|cfg_half_i);
      if (state_q == ST_STOPPED) begin
        count_q   <= '0;
        div_clk_q <= 1'b0;
        if (cfg_nz)
          half_q <= cfg_half_i;
        if (en_i)
          state_q <= ST_RUN;
      end else if (stop_now) begin
        // Output is low after this edge, so any change can land immediately.
        state_q   <= ST_STOPPED;
        count_q   <= '0;
        div_clk_q <= 1'b0;
        half_q    <= stop_half;
        pend_vld  <= 1'b0;
      end else begin
        if (boundary) begin
          count_q   <= '0;
          div_clk_q <= ~div_clk_q;
          tick_q    <= ~div_clk_q;
        end else begin
          count_q <= count_q + ONE;
        end
        if ((state_q == ST_RUN) && !en_i)
          state_q <= ST_DRAIN;
        if (fall && pend_vld) begin
          half_q   <= pend_q;
          pend_vld <= 1'b0;
        end
        if (cfg_nz) begin
          pend_q   <= cfg_half_i;
          pend_vld <= 1'b1;
        end
      end
    end
  end

  assign cfg_ready_o = ~pend_vld;
  assign cfg_err_o   = cfg_err_q;
  assign div_clk_o   = div_clk_q;
  assign tick_o      = tick_q;
  assign running_o   = (state_q == ST_RUN);
  assign cur_half_o  = half_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Self-checking bench for clk_div_ctrl: directed scenarios followed by random traffic,
// every cycle compared against a period-position reference model.
module tb_clk_div_ctrl;
  localparam int CNT_W    = 8;
  localparam int DEF_HALF = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             cfg_valid;
  logic [CNT_W-1:0] cfg_half;
  logic             cfg_ready;
  logic             cfg_err;
  logic             div_clk;
  logic             tick;
  logic             running;
  logic [CNT_W-1:0] cur_half;

  int errors = 0;
  int checks = 0;

  // Model: position within the full period, output high for the second half of it.
  int m_mode;  // 0 stopped, 1 run, 2 drain
  int m_pos;
  int m_half;
  int m_pend_half;
  bit m_pend;
  bit m_out;
  bit m_tick;
  bit m_err;

  always #5 clk = ~clk;

  clk_div_ctrl #(.CNT_W(CNT_W), .DEF_HALF(DEF_HALF)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .en_i       (en),
    .cfg_valid_i(cfg_valid),
    .cfg_half_i (cfg_half),
    .cfg_ready_o(cfg_ready),
    .cfg_err_o  (cfg_err),
    .div_clk_o  (div_clk),
    .tick_o     (tick),
    .running_o  (running),
    .cur_half_o (cur_half)
  );

  task automatic stopModel(input bit acc_nz, input int ch);
    m_mode = 0;
    m_pos  = 0;
    m_out  = 0;
    if (acc_nz) m_half = ch;
    else if (m_pend) m_half = m_pend_half;
    m_pend = 0;
  endtask

  task automatic modelStep(input bit e, input bit cv, input int ch, input bit r);
    bit acc;
    bit acc_nz;
    bit falling;
    if (r) begin
      m_mode = 0; m_pos = 0; m_half = DEF_HALF; m_pend = 0;
      m_out = 0; m_tick = 0; m_err = 0;
      return;
    end
    acc    = cv && !m_pend;
    acc_nz = acc && (ch != 0);
    m_err  = acc && (ch == 0);
    m_tick = 0;
    if (m_mode == 0) begin
      if (acc_nz) m_half = ch;
      m_out = 0;
      m_pos = 0;
      if (e) m_mode = 1;
    end else if (m_mode == 1 && !e && !m_out) begin
      stopModel(acc_nz, ch);
    end else begin
      m_pos++;
      falling = 0;
      if (m_pos == 2 * m_half) begin
        m_pos   = 0;
        falling = 1;
      end
      if (falling && (m_mode == 2 || !e)) begin
        stopModel(acc_nz, ch);
      end else begin
        if (m_mode == 1 && !e) m_mode = 2;
        if (falling && m_pend) begin
          m_half = m_pend_half;
          m_pend = 0;
        end
        if (acc_nz) begin
          m_pend_half = ch;
          m_pend      = 1;
        end
        m_tick = (m_pos == m_half);
        m_out  = (m_pos >= m_half);
      end
    end
  endtask

  task automatic checkOne(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic checkOutput();
    checkOne("div_clk", int'(div_clk), int'(m_out));
    checkOne("tick", int'(tick), int'(m_tick));
    checkOne("running", int'(running), (m_mode == 1) ? 1 : 0);
    checkOne("cur_half", int'(cur_half), m_half);
    checkOne("cfg_ready", int'(cfg_ready), m_pend ? 0 : 1);
    checkOne("cfg_err", int'(cfg_err), int'(m_err));
  endtask

  task automatic applyStimulus(input bit e, input bit cv, input int ch, input bit r);
    en        = e;
    cfg_valid = cv;
    cfg_half  = CNT_W'(ch);
    rst       = r;
    @(posedge clk);
    modelStep(e, cv, ch, r);
    #1;
    checkOutput();
  endtask

  task automatic runCycles(input bit e, input int n);
    for (int i = 0; i < n; i++) applyStimulus(e, 1'b0, 0, 1'b0);
  endtask

  // Advance until the model's output reaches the wanted level, within a bounded budget.
  task automatic runUntilLevel(input bit e, input bit lvl);
    int k;
    k = 0;
    while (m_out != lvl && k < 600) begin
      applyStimulus(e, 1'b0, 0, 1'b0);
      k++;
    end
    checks++;
    if (k >= 600) begin
      errors++;
      $error("[TB] FAIL wait_level observed=%0d expected=%0d", int'(m_out), int'(lvl));
    end
  endtask

  initial begin
    en = 0; cfg_valid = 0; cfg_half = '0; rst = 1;
    m_mode = 0; m_pos = 0; m_half = DEF_HALF; m_pend = 0; m_pend_half = 0;
    m_out = 0; m_tick = 0; m_err = 0;

    $display("[TB] reset and default divide");
    applyStimulus(1'b0, 1'b0, 0, 1'b1);
    applyStimulus(1'b0, 1'b0, 0, 1'b1);
    checkOne("reset_half", int'(cur_half), DEF_HALF);
    checkOne("reset_ready", int'(cfg_ready), 1);
    runCycles(1'b1, 32);

    $display("[TB] divisor change mid high phase");
    runUntilLevel(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 0, 1'b0);
    applyStimulus(1'b1, 1'b1, 2, 1'b0);
    checkOne("pending_ready", int'(cfg_ready), 0);
    runCycles(1'b1, 20);

    $display("[TB] zero divisor rejected");
    applyStimulus(1'b1, 1'b1, 0, 1'b0);
    checkOne("zero_err", int'(cfg_err), 1);
    runCycles(1'b1, 6);

    $display("[TB] clean stop from high and low phase");
    applyStimulus(1'b1, 1'b1, 5, 1'b0);
    runCycles(1'b1, 12);
    runUntilLevel(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 0, 1'b0);
    runCycles(1'b0, 12);
    checkOne("stopped_low", int'(div_clk), 0);
    runCycles(1'b1, 3);
    runUntilLevel(1'b1, 1'b1);
    runUntilLevel(1'b1, 1'b0);
    runCycles(1'b0, 4);

    $display("[TB] config and enable together while stopped");
    applyStimulus(1'b1, 1'b1, 3, 1'b0);
    runCycles(1'b1, 16);

    $display("[TB] reset with pending change");
    applyStimulus(1'b1, 1'b1, 5, 1'b0);
    runCycles(1'b1, 8);
    runUntilLevel(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1, 7, 1'b0);
    applyStimulus(1'b1, 1'b0, 0, 1'b1);
    checkOne("rst_half", int'(cur_half), DEF_HALF);
    checkOne("rst_div", int'(div_clk), 0);
    runCycles(1'b0, 3);

    $display("[TB] divide by one and random traffic");
    applyStimulus(1'b1, 1'b1, 1, 1'b0);
    runCycles(1'b1, 8);
    for (int i = 0; i < 1500; i++) begin
      applyStimulus(($urandom_range(0, 9) != 0),
                    ($urandom_range(0, 7) == 0),
                    int'($urandom_range(0, 6)),
                    ($urandom_range(0, 199) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
